// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register with a skid slot, debug step gating, flush and stop-flag latching.
// Bubbles always present an all-zero control word so downstream sees a NOP.
module pipe_stage_skid #(
  parameter int DATA_W     = 101,
  parameter int CTRL_W     = 11,
  parameter int FLUSH_DATA = 1,
  parameter int STOP_BIT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_step,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_count,
  output logic              o_halted
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic              halted_reg;

  logic skid_valid;
  logic accept;
  logic xfer;

  assign skid_valid = (state_reg == FULL);
  assign o_ready    = rst & i_step & ~skid_valid & ~halted_reg;
  assign o_valid    = (state_reg != EMPTY);
  assign accept     = i_step & i_valid & o_ready & ~i_flush;
  assign xfer       = i_step & o_valid & i_ready;

  assign o_data   = main_data_reg;
  assign o_ctrl   = main_ctrl_reg;
  assign o_count  = state_reg;
  assign o_halted = halted_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
      halted_reg    <= 1'b0;
    end else if (i_step) begin
      if (i_flush) begin
        // A downstream transfer in this cycle still completes; only held entries are dropped.
        state_reg     <= EMPTY;
        main_ctrl_reg <= '0;
        skid_ctrl_reg <= '0;
        halted_reg    <= 1'b0;
        if (FLUSH_DATA != 0) begin
          main_data_reg <= '0;
          skid_data_reg <= '0;
        end
      end else begin
        if (accept && i_ctrl[STOP_BIT]) begin
          halted_reg <= 1'b1;
        end
        case (state_reg)
          EMPTY: begin
            if (accept) begin
              state_reg     <= ONE;
              main_data_reg <= i_data;
              main_ctrl_reg <= i_ctrl;
            end
          end
          ONE: begin
            if (accept && xfer) begin
              main_data_reg <= i_data;
              main_ctrl_reg <= i_ctrl;
            end else if (accept) begin
              state_reg     <= FULL;
              skid_data_reg <= i_data;
              skid_ctrl_reg <= i_ctrl;
            end else if (xfer) begin
              // Data is left as-is; only the control word must read as a NOP.
              state_reg     <= EMPTY;
              main_ctrl_reg <= '0;
            end
          end
          FULL: begin
            if (xfer) begin
              state_reg     <= ONE;
              main_data_reg <= skid_data_reg;
              main_ctrl_reg <= skid_ctrl_reg;
            end
          end
          default: begin
            state_reg     <= EMPTY;
            main_ctrl_reg <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int DATA_W = 101;
  localparam int CTRL_W = 11;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_step;
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [CTRL_W-1:0] i_ctrl;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [CTRL_W-1:0] o_ctrl;
  logic [1:0]        o_count;
  logic              o_halted;

  int checks = 0;
  int errors = 0;

  ent_t              m_q[$];
  logic              m_halt;
  logic [DATA_W-1:0] m_empty_d;

  pipe_stage_skid #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLUSH_DATA(1), .STOP_BIT(0)
  ) dut (
    .clk(clk), .rst(rst), .i_step(i_step), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_ctrl(i_ctrl),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_ctrl(o_ctrl),
    .o_count(o_count), .o_halted(o_halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic cycle(input logic r, input logic s, input logic f, input logic v,
                       input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic rd);
    logic exp_ready, acc, xf;
    ent_t e;
    @(negedge clk);
    rst = r; i_step = s; i_flush = f; i_valid = v; i_data = d; i_ctrl = c; i_ready = rd;
    #1;
    exp_ready = r & s & (m_q.size() < 2) & ~m_halt;
    chk("o_valid", o_valid, m_q.size() != 0);
    chk("o_count", o_count, m_q.size());
    chk("o_ready", o_ready, exp_ready);
    chk("o_halted", o_halted, m_halt);
    chk("o_ctrl", o_ctrl, (m_q.size() != 0) ? m_q[0].c : '0);
    chk("o_data", o_data, (m_q.size() != 0) ? m_q[0].d : m_empty_d);
    acc = exp_ready & v & ~f;
    xf  = s & (m_q.size() != 0) & rd;
    @(posedge clk);
    if (!r) begin
      m_q.delete();
      m_halt = 1'b0;
      m_empty_d = '0;
    end else if (s) begin
      if (f) begin
        m_q.delete();
        m_halt = 1'b0;
        m_empty_d = '0;
      end else begin
        if (xf) begin
          e = m_q.pop_front();
          if (m_q.size() == 0) m_empty_d = e.d;
        end
        if (acc) begin
          e.d = d; e.c = c;
          m_q.push_back(e);
          if (c[0]) m_halt = 1'b1;
        end
      end
    end
    $display("cycle rst=%0b step=%0b flush=%0b valid=%0b ready=%0b data=%0h ctrl=%0h -> count=%0d halted=%0b",
             r, s, f, v, rd, d, c, m_q.size(), m_halt);
  endtask

  initial begin
    logic [DATA_W-1:0] rd_data;
    logic [CTRL_W-1:0] rc;
    m_halt = 1'b0; m_empty_d = '0;
    rst = 1'b0; i_step = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    i_data = '0; i_ctrl = '0; i_ready = 1'b0;

    // Reset state
    cycle(0, 1, 0, 0, '0, '0, 0);
    cycle(0, 1, 0, 0, '0, '0, 0);
    #2;
    chk("rst_count", o_count, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);

    // Single entry, one-cycle latency
    cycle(1, 1, 0, 1, 'hA, '0, 1);
    #2;
    chk("lat_valid", o_valid, 1);
    chk("lat_data", o_data, 'hA);
    chk("lat_count", o_count, 1);
    cycle(1, 1, 0, 0, '0, '0, 1);

    // Fill to FULL, then drain in order
    cycle(1, 1, 0, 1, 'h1, 'h2, 0);
    cycle(1, 1, 0, 1, 'h2, 'h4, 0);
    #2;
    chk("full_count", o_count, 2);
    chk("full_ready", o_ready, 0);
    chk("full_data", o_data, 'h1);
    cycle(1, 1, 0, 0, '0, '0, 1);
    #2;
    chk("drain1_data", o_data, 'h2);
    chk("drain1_count", o_count, 1);
    cycle(1, 1, 0, 0, '0, '0, 1);
    #2;
    chk("drain2_count", o_count, 0);

    // Flush while FULL with a valid input present
    cycle(1, 1, 0, 1, 'h33, 'h6, 0);
    cycle(1, 1, 0, 1, 'h44, 'ha0, 0);
    cycle(1, 1, 1, 1, 'h3, 'h2, 0);
    #2;
    chk("flush_count", o_count, 0);
    chk("flush_ctrl", o_ctrl, 0);
    chk("flush_data", o_data, 0);
    cycle(1, 1, 0, 0, '0, '0, 0);

    // Step held low: everything frozen
    cycle(1, 1, 0, 1, 'h5, 'h8, 0);
    for (int k = 0; k < 5; k++) cycle(1, 0, 0, 1, 'h7, 'h2, 1);
    #2;
    chk("freeze_count", o_count, 1);
    chk("freeze_data", o_data, 'h5);
    cycle(1, 1, 0, 0, '0, '0, 1);

    // Stop flag: halt, drain, flush clears
    cycle(1, 1, 0, 1, 'h9, 'h1, 0);
    #2;
    chk("halt_set", o_halted, 1);
    chk("halt_ready", o_ready, 0);
    cycle(1, 1, 0, 1, 'h8, 'h0, 1);
    #2;
    chk("halt_drain", o_count, 0);
    chk("halt_hold", o_halted, 1);
    cycle(1, 1, 1, 0, '0, '0, 0);
    #2;
    chk("halt_clear", o_halted, 0);
    chk("halt_ready1", o_ready, 1);

    // Reset while FULL and halted
    cycle(1, 1, 0, 1, 'h11, 'h10, 0);
    cycle(1, 1, 0, 1, 'h12, 'h1, 0);
    cycle(0, 1, 1, 1, 'h13, 'h2, 1);
    #2;
    chk("rst2_count", o_count, 0);
    chk("rst2_data", o_data, 0);
    chk("rst2_ctrl", o_ctrl, 0);
    chk("rst2_halted", o_halted, 0);
    chk("rst2_ready", o_ready, 0);
    cycle(1, 1, 0, 0, '0, '0, 0);
    #2;
    chk("rst2_release", o_ready, 1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rd_data = {$urandom, $urandom, $urandom, $urandom};
      rc = CTRL_W'($urandom);
      rc[0] = ($urandom_range(0, 29) == 0);
      cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 24) == 0), $urandom_range(0, 9) < 6,
            rd_data, rc, $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
